// File: rtl/cpu_pkg.sv
// Shared CPU datapath constants used by the register file and its write arbiter.
package cpu_pkg;

    localparam int DATA_W   = 24;
    localparam int ADDR_W   = 4;
    localparam int NUM_REGS = 2 ** ADDR_W;

    typedef enum logic {
        SIDE_A = 1'b0,
        SIDE_B = 1'b1
    } side_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: combinational grant, pointer flips to the losing side.
module rr_arb2
    import cpu_pkg::*;
(
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_req_a,
    input  logic i_req_b,
    output logic o_gnt_a,
    output logic o_gnt_b
);

    side_e r_ptr;

    always_comb begin
        o_gnt_a = 1'b0;
        o_gnt_b = 1'b0;
        // Grants are suppressed during reset so no request slips into the write port.
        if (!i_rst) begin
            if (i_req_a && (!i_req_b || r_ptr == SIDE_A)) begin
                o_gnt_a = 1'b1;
            end else if (i_req_b) begin
                o_gnt_b = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ptr <= SIDE_A;
        end else if (o_gnt_a) begin
            r_ptr <= SIDE_B;
        end else if (o_gnt_b) begin
            r_ptr <= SIDE_A;
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Merges ALU and load writebacks onto one register-file write port and tracks
// outstanding destination reservations in a busy scoreboard.
module regfile_write_arbiter #(
    parameter int DATA_W   = cpu_pkg::DATA_W,
    parameter int ADDR_W   = cpu_pkg::ADDR_W,
    parameter int NUM_REGS = cpu_pkg::NUM_REGS
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic                ReqA,
    input  logic [ADDR_W-1:0]   RdA,
    input  logic [DATA_W-1:0]   DataA,
    output logic                GntA,
    input  logic                ReqB,
    input  logic [ADDR_W-1:0]   RdB,
    input  logic [DATA_W-1:0]   DataB,
    output logic                GntB,
    input  logic                Reserve,
    input  logic [ADDR_W-1:0]   ReserveRD,
    input  logic [ADDR_W-1:0]   RS,
    input  logic [ADDR_W-1:0]   RT,
    output logic                BusyRS,
    output logic                BusyRT,
    output logic                RegWrite,
    output logic [ADDR_W-1:0]   RD,
    output logic [DATA_W-1:0]   WriteData,
    output logic [NUM_REGS-1:0] Busy
);

    logic                w_gnt_a;
    logic                w_gnt_b;
    logic [NUM_REGS-1:0] w_busy_next;
    logic                r_regwrite;
    logic [ADDR_W-1:0]   r_rd;
    logic [DATA_W-1:0]   r_wdata;
    logic [NUM_REGS-1:0] r_busy;

    rr_arb2 u_arb (
        .i_clk   (Clock),
        .i_rst   (Reset),
        .i_req_a (ReqA),
        .i_req_b (ReqB),
        .o_gnt_a (w_gnt_a),
        .o_gnt_b (w_gnt_b)
    );

    // Clear on the retiring write first, then set, so a same-edge reserve wins.
    always_comb begin
        w_busy_next = r_busy;
        if (r_regwrite) begin
            w_busy_next[r_rd] = 1'b0;
        end
        if (Reserve) begin
            w_busy_next[ReserveRD] = 1'b1;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_regwrite <= 1'b0;
            r_rd       <= '0;
            r_wdata    <= '0;
            r_busy     <= '0;
        end else begin
            r_regwrite <= w_gnt_a | w_gnt_b;
            r_busy     <= w_busy_next;
            if (w_gnt_a) begin
                r_rd    <= RdA;
                r_wdata <= DataA;
            end else if (w_gnt_b) begin
                r_rd    <= RdB;
                r_wdata <= DataB;
            end
        end
    end

    assign GntA      = w_gnt_a;
    assign GntB      = w_gnt_b;
    assign RegWrite  = r_regwrite;
    assign RD        = r_rd;
    assign WriteData = r_wdata;
    assign Busy      = r_busy;
    assign BusyRS    = r_busy[RS];
    assign BusyRT    = r_busy[RT];

endmodule

// File: doc/regfile_write_arbiter.md
REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  DATA_W  24  register data width
  ADDR_W  4  register index width
  NUM_REGS  16  register count, equal to 2**ADDR_W
REQ-002 Ports SHALL be, one per line: name  direction  width  meaning.
  Clock  in  1  single clock; all state updates on its rising edge
  Reset  in  1  reset, synchronous, active-high
  ReqA  in  1  requester A (ALU writeback) write valid
  RdA  in  ADDR_W  requester A destination register
  DataA  in  DATA_W  requester A write data
  GntA  out  1  requester A accepted this cycle
  ReqB  in  1  requester B (load writeback) write valid
  RdB  in  ADDR_W  requester B destination register
  DataB  in  DATA_W  requester B write data
  GntB  out  1  requester B accepted this cycle
  Reserve  in  1  issue stage reserves a destination register
  ReserveRD  in  ADDR_W  register being reserved
  RS  in  ADDR_W  source register query 1
  RT  in  ADDR_W  source register query 2
  BusyRS  out  1  RS has an outstanding reservation
  BusyRT  out  1  RT has an outstanding reservation
  RegWrite  out  1  register-file write enable
  RD  out  ADDR_W  register-file write index
  WriteData  out  DATA_W  register-file write data
  Busy  out  NUM_REGS  scoreboard vector; bit i = register i reserved

Function
REQ-003 GntA/GntB SHALL be combinational from ReqA, ReqB and the priority pointer; at most one SHALL be 1 per cycle.
REQ-004 Single request SHALL be granted in the same cycle regardless of pointer.
REQ-005 Both requesting: grant SHALL go to the side named by the pointer (0=A, 1=B).
REQ-006 After any grant the pointer SHALL point to the non-granted side; with no grant it SHALL hold.
REQ-007 A granted request SHALL appear on RegWrite=1, RD, WriteData exactly one cycle later (registered, latency 1); with no grant RegWrite SHALL be 0 next cycle and RD/WriteData SHALL hold.
REQ-008 Throughput SHALL be one write per cycle; the write port never back-pressures.
REQ-009 A non-granted requester SHALL hold Req/Rd/Data stable until granted; the arbiter samples data only in the grant cycle.
REQ-010 Both requesters targeting the same RD SHALL be serviced as two sequential writes in grant order; no merging.
REQ-011 Register 0 SHALL be treated like every other register (writable, reservable).
REQ-012 Reserve=1 SHALL set Busy[ReserveRD] at the next edge.
REQ-013 Busy[RD] SHALL clear at the edge ending a cycle with RegWrite=1 (the same edge the register file stores the data).
REQ-014 Set and clear of the same register at the same edge: set SHALL win.
REQ-015 BusyRS = Busy[RS], BusyRT = Busy[RT], combinational, no bypass of same-cycle set/clear.
REQ-016 Writes to a non-reserved register SHALL be performed normally and leave Busy unchanged.

Reset
REQ-017 Reset=1 at an edge SHALL force pointer=0 (A first), Busy=0, RegWrite=0, RD=0, WriteData=0, overriding every in-flight grant and reservation.
REQ-018 During Reset=1, GntA and GntB SHALL be 0; a request presented in the reset cycle SHALL not be written.

Structure
REQ-019 DATA_W, ADDR_W, NUM_REGS SHALL come from the shared package cpu_pkg, which also serves the register file.
REQ-020 The two-way round-robin grant and pointer SHALL be one sub-module, rr_arb2; scoreboard and output register stay in the top.

Verification
REQ-021 Reset then ReqA only, RdA=3, DataA=0x00ABCD -> GntA same cycle; next cycle RegWrite=1, RD=3, WriteData=0x00ABCD.
REQ-022 ReqA and ReqB held 4 cycles, RdA=1, RdB=2 -> grants A,B,A,B; RegWrite stays 1 with RD 1,2,1,2 from cycle 2.
REQ-023 Reserve RD=5, then ReqB RdB=5 -> Busy[5]=1 and BusyRS=1 for RS=5 until the edge after RegWrite with RD=5, then 0.
REQ-024 Reserve RD=7 in the same cycle RegWrite=1 with RD=7 -> Busy[7]=1 after the edge.
REQ-025 Both Req with RdA=RdB=9, DataA=0x000001, DataB=0x000002 -> two consecutive writes to 9 in pointer order; final value from the later write.
REQ-026 Reset asserted one cycle after a grant with Busy[4]=1 -> next edge RegWrite=0, Busy=0, pointer=A; both Req then -> GntA first.
